// File: rtl/imm_ext_fifo.sv
// Immediate-extension unit (zero/sign/upper/branch-offset) with a small result FIFO.
// Optional IMM_EXT_STATS_EN macro adds stat_pops and stat_full_stall outputs.
module imm_ext_fifo #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_imm,
   input  logic [1:0]                 in_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
`ifdef IMM_EXT_STATS_EN
   output logic [31:0]                stat_pops,
   output logic                       stat_full_stall,
`endif
   output logic [$clog2(DEPTH):0]     out_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [OUT_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [OUT_W-1:0] ext;
   logic [OUT_W-1:0] sext;
   logic             push;
   logic             pop;

   assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

   always_comb begin
      ext = '0;
      case (in_mode)
         2'b00:   ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
         2'b01:   ext = sext;
         2'b10:   ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
         default: ext = {sext[OUT_W-3:0], 2'b00};
      endcase
   end

   // Readiness depends only on occupancy, so a full FIFO refuses a push even during a pop.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign out_count = count;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= ext;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

`ifdef IMM_EXT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pops       <= '0;
         stat_full_stall <= 1'b0;
      end else begin
         if (pop && (stat_pops != 32'hFFFF_FFFF)) stat_pops <= stat_pops + 32'd1;
         stat_full_stall <= in_valid && !in_ready;
      end
   end
`endif

endmodule
